ram_access_arbiter: RTL and testbench

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

---
 rtl/ram_access_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_access_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port RAM between a host register-file
// port (read/write, fixed two-cycle latency) and a streaming core read port.
// The core has priority. Optional macro RAM_ARB_STARVE_GUARD_EN adds a starve
// counter that forces one host slot after starve_limit core reads while the
// host is waiting.
module ram_access_arbiter #(
  parameter int addrWidth    = 9,
  parameter int dataWidth    = 91,
  parameter int starve_limit = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [addrWidth-1:0] host_addr,
  input  logic [dataWidth-1:0] host_wdata,
  output logic                 host_ack,
  output logic [dataWidth-1:0] host_rdata,
  input  logic                 core_req,
  input  logic [addrWidth-1:0] core_addr,
  output logic                 core_stall,
  output logic                 core_valid,
  output logic [dataWidth-1:0] core_rdata,
  output logic [addrWidth-1:0] ram_addr,
  output logic [dataWidth-1:0] ram_wdata,
  input  logic [dataWidth-1:0] ram_rdata,
  output logic                 chip_select_n,
  output logic                 wr_en_n,
  output logic                 output_en_n
);

  typedef enum logic [1:0] {IDLE, CORE, HOST, ACK} state_t;

  state_t               state_q, state_d;
  logic                 core_vld_q, core_vld_d;
  logic                 host_we_q, host_we_d;
  logic [dataWidth-1:0] host_rdata_q, host_rdata_d;
  logic                 preempt;

`ifdef RAM_ARB_STARVE_GUARD_EN
  logic [7:0] starve_q, starve_d;

  // Preempt the core once the host has watched starve_limit core reads go by.
  always_comb begin
    preempt = (state_q == CORE) && core_req && host_req &&
              (starve_q == 8'(starve_limit));
  end

  // Count CORE cycles with a waiting host; cleared whenever CORE is left.
  always_comb begin
    starve_d = starve_q;
    if (state_d != CORE)
      starve_d = '0;
    else if (state_q == CORE && host_req)
      starve_d = starve_q + 8'd1;
  end

  // Starve counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign preempt = 1'b0;
`endif

  // Next state, RAM strobes and port outputs.
  always_comb begin
    state_d       = state_q;
    core_vld_d    = 1'b0;
    host_we_d     = host_we_q;
    host_rdata_d  = host_rdata_q;
    host_rdata    = host_rdata_q;
    host_ack      = 1'b0;
    core_stall    = core_req;
    ram_addr      = host_addr;
    ram_wdata     = host_wdata;
    chip_select_n = 1'b1;
    wr_en_n       = 1'b1;
    output_en_n   = 1'b1;
    case (state_q)
      IDLE: begin
        if (core_req)      state_d = CORE;
        else if (host_req) state_d = HOST;
      end
      CORE: begin
        if (!core_req) begin
          state_d = host_req ? HOST : IDLE;
        end else if (preempt) begin
          state_d = HOST;
        end else begin
          ram_addr      = core_addr;
          chip_select_n = 1'b0;
          output_en_n   = 1'b0;
          core_stall    = 1'b0;
          core_vld_d    = 1'b1;
        end
      end
      HOST: begin
        chip_select_n = 1'b0;
        wr_en_n       = !host_we;
        output_en_n   = host_we;
        host_we_d     = host_we;
        state_d       = ACK;
      end
      ACK: begin
        host_ack = 1'b1;
        if (!host_we_q) begin
          host_rdata   = ram_rdata;
          host_rdata_d = ram_rdata;
        end
        state_d = core_req ? CORE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // While in reset nothing is issued and no ack is given.
    if (!rst_n) begin
      chip_select_n = 1'b1;
      wr_en_n       = 1'b1;
      output_en_n   = 1'b1;
      core_stall    = core_req;
      host_ack      = 1'b0;
      core_vld_d    = 1'b0;
      host_rdata    = host_rdata_q;
    end
  end

  assign core_valid = core_vld_q;
  assign core_rdata = ram_rdata;

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      core_vld_q   <= 1'b0;
      host_we_q    <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      core_vld_q   <= core_vld_d;
      host_we_q    <= host_we_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: behavioural RAM, reference memory image and a
// queue of expected core read data popped on every core_valid.
module tb_ram_access_arbiter;
  localparam int AW = 9;
  localparam int DW = 91;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_req, host_we, host_ack;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          core_req, core_stall, core_valid;
  logic [AW-1:0] core_addr, ram_addr;
  logic [DW-1:0] core_rdata, ram_wdata, ram_rdata;
  logic          chip_select_n, wr_en_n, output_en_n;

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [DW-1:0] core_q  [$];
  logic [DW-1:0] last_rd;
  int vec_cnt = 0;
  int err_cnt = 0;
  int valid_cnt = 0;

  always #5 clk = ~clk;

  ram_access_arbiter #(.addrWidth(AW), .dataWidth(DW), .starve_limit(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .core_req(core_req), .core_addr(core_addr), .core_stall(core_stall),
    .core_valid(core_valid), .core_rdata(core_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .chip_select_n(chip_select_n), .wr_en_n(wr_en_n), .output_en_n(output_en_n)
  );

  // Behavioural synchronous RAM: Q one cycle after a selected read.
  always @(posedge clk) begin
    if (!chip_select_n) begin
      if (!wr_en_n)          ram[ram_addr] <= ram_wdata;
      else if (!output_en_n) ram_rdata     <= ram[ram_addr];
    end
  end

  function automatic logic [DW-1:0] pat(int i);
    return {27'(i), 32'hA5A50000 | 32'(i), 32'(i * 7 + 1)};
  endfunction

  // Scoreboard consumer: every core_valid must match the oldest expected read.
  always @(negedge clk) begin
    if (core_valid === 1'b1) begin
      valid_cnt++;
      vec_cnt++;
      if (core_q.size() == 0) begin
        err_cnt++;
        $display("FAIL core_valid_unexpected: got data %h, none expected", core_rdata);
      end else begin
        logic [DW-1:0] e;
        e = core_q.pop_front();
        if (core_rdata !== e) begin
          err_cnt++;
          $display("FAIL core_rdata: got %h want %h", core_rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req = 1'b1; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; core_addr = '0;
    tick(); tick();
    @(negedge clk);
    vec_cnt++;
    if ({chip_select_n, wr_en_n, output_en_n} !== 3'b111) begin
      err_cnt++; $display("FAIL reset_strobes: got %b want 111", {chip_select_n, wr_en_n, output_en_n});
    end
    vec_cnt++;
    if (host_ack !== 1'b0 || core_valid !== 1'b0 || host_rdata !== '0) begin
      err_cnt++; $display("FAIL reset_outputs: ack %b valid %b rdata %h want 0 0 0", host_ack, core_valid, host_rdata);
    end
    vec_cnt++;
    if (core_stall !== 1'b1) begin
      err_cnt++; $display("FAIL reset_stall_hi: got %b want 1", core_stall);
    end
    core_req = 1'b0;
    #1;
    vec_cnt++;
    if (core_stall !== 1'b0) begin
      err_cnt++; $display("FAIL reset_stall_lo: got %b want 0", core_stall);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One host access from IDLE: strobes at T+1, ack at T+2, data with the ack.
  task automatic test_host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    @(negedge clk);
    vec_cnt++;
    if (chip_select_n !== 1'b1 || host_ack !== 1'b0 || ram_wdata !== d) begin
      err_cnt++; $display("FAIL host_idle: csn %b ack %b wdata %h want 1 0 %h", chip_select_n, host_ack, ram_wdata, d);
    end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (chip_select_n !== 1'b0 || wr_en_n !== !we || output_en_n !== we || ram_addr !== a || host_ack !== 1'b0) begin
      err_cnt++; $display("FAIL host_issue: csn %b wen %b oen %b addr %h ack %b we %b addr_want %h",
                          chip_select_n, wr_en_n, output_en_n, ram_addr, host_ack, we, a);
    end
    tick();
    if (we) exp_mem[a] = d;
    else    last_rd = exp_mem[a];
    @(negedge clk);
    vec_cnt++;
    if (host_ack !== 1'b1 || host_rdata !== last_rd || chip_select_n !== 1'b1) begin
      err_cnt++; $display("FAIL host_ack: ack %b rdata %h csn %b want 1 %h 1", host_ack, host_rdata, chip_select_n, last_rd);
    end
    tick();
    host_req = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (host_ack !== 1'b0 || host_rdata !== last_rd) begin
      err_cnt++; $display("FAIL host_after: ack %b rdata %h want 0 %h", host_ack, host_rdata, last_rd);
    end
    tick();
  endtask

  // Issue cycle check plus scoreboard push for one core read.
  task automatic core_issue(input logic [AW-1:0] a);
    core_addr = a;
    @(negedge clk);
    vec_cnt++;
    if (core_stall !== 1'b0 || chip_select_n !== 1'b0 || output_en_n !== 1'b0 || wr_en_n !== 1'b1 || ram_addr !== a) begin
      err_cnt++; $display("FAIL core_issue: stall %b csn %b oen %b wen %b addr %h want 0 0 0 1 %h",
                          core_stall, chip_select_n, output_en_n, wr_en_n, ram_addr, a);
    end
    core_q.push_back(exp_mem[a]);
    tick();
  endtask

  task automatic core_idle_stall(input string nm);
    @(negedge clk);
    vec_cnt++;
    if (core_stall !== 1'b1 || chip_select_n !== 1'b1) begin
      err_cnt++; $display("FAIL %s: stall %b csn %b want 1 1", nm, core_stall, chip_select_n);
    end
    tick();
  endtask

  task automatic test_core_stream();
    int v0;
    v0 = valid_cnt;
    core_req = 1'b1; core_addr = '0;
    core_idle_stall("stream_idle_stall");
    for (int i = 0; i < 16; i++) core_issue(AW'(i));
    core_req = 1'b0;
    tick(); tick();
    vec_cnt++;
    if (valid_cnt - v0 !== 16) begin
      err_cnt++; $display("FAIL stream_valid_count: got %0d want 16", valid_cnt - v0);
    end
  endtask

  task automatic test_tie();
    core_req = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 9'h005;
    core_idle_stall("tie_idle_stall");
    for (int i = 0; i < 3; i++) begin
      core_issue(AW'(9'h020 + i));
      vec_cnt++;
      if (host_ack !== 1'b0) begin
        err_cnt++; $display("FAIL tie_no_ack: got %b want 0", host_ack);
      end
    end
    core_req = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (chip_select_n !== 1'b1 || core_stall !== 1'b0) begin
      err_cnt++; $display("FAIL tie_core_drop: csn %b stall %b want 1 0", chip_select_n, core_stall);
    end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (chip_select_n !== 1'b0 || output_en_n !== 1'b0 || ram_addr !== 9'h005) begin
      err_cnt++; $display("FAIL tie_host_issue: csn %b oen %b addr %h want 0 0 005", chip_select_n, output_en_n, ram_addr);
    end
    tick();
    last_rd = exp_mem[5];
    @(negedge clk);
    vec_cnt++;
    if (host_ack !== 1'b1 || host_rdata !== last_rd) begin
      err_cnt++; $display("FAIL tie_host_ack: ack %b rdata %h want 1 %h", host_ack, host_rdata, last_rd);
    end
    tick();
    host_req = 1'b0;
    tick();
  endtask

`ifdef RAM_ARB_STARVE_GUARD_EN
  task automatic test_starve();
    logic [DW-1:0] d;
    d = {27'h1234567, 32'hCAFEF00D, 32'h0BADBEEF};
    core_req = 1'b1; host_req = 1'b0;
    core_idle_stall("starve_idle_stall");
    core_issue(9'h030);
    core_issue(9'h031);
    host_req = 1'b1; host_we = 1'b1; host_addr = 9'h040; host_wdata = d;
    for (int i = 0; i < SL; i++) core_issue(AW'(9'h032 + i));
    core_addr = 9'h036;
    core_idle_stall("starve_preempt");
    @(negedge clk);
    vec_cnt++;
    if (wr_en_n !== 1'b0 || core_stall !== 1'b1 || ram_addr !== 9'h040) begin
      err_cnt++; $display("FAIL starve_host_issue: wen %b stall %b addr %h want 0 1 040", wr_en_n, core_stall, ram_addr);
    end
    tick();
    exp_mem[9'h040] = d;
    @(negedge clk);
    vec_cnt++;
    if (host_ack !== 1'b1 || core_stall !== 1'b1) begin
      err_cnt++; $display("FAIL starve_ack: ack %b stall %b want 1 1", host_ack, core_stall);
    end
    tick();
    host_req = 1'b0;
    core_issue(9'h036);
    core_issue(9'h040);
    core_req = 1'b0;
    tick(); tick();
  endtask
`else
  task automatic test_strict_priority();
    core_req = 1'b1; host_req = 1'b0;
    core_idle_stall("strict_idle_stall");
    host_req = 1'b1; host_we = 1'b0; host_addr = 9'h005;
    for (int i = 0; i < 2 * SL + 2; i++) begin
      core_issue(AW'(9'h050 + i));
      vec_cnt++;
      if (host_ack !== 1'b0) begin
        err_cnt++; $display("FAIL strict_no_ack: got %b want 0", host_ack);
      end
    end
    core_req = 1'b0;
    tick(); tick();
    last_rd = exp_mem[5];
    @(negedge clk);
    vec_cnt++;
    if (host_ack !== 1'b1 || host_rdata !== last_rd) begin
      err_cnt++; $display("FAIL strict_ack: ack %b rdata %h want 1 %h", host_ack, host_rdata, last_rd);
    end
    tick();
    host_req = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    // Reset during HOST: no ack afterwards.
    host_req = 1'b1; host_we = 1'b1; host_addr = 9'h007; host_wdata = pat(999);
    tick();
    rst_n = 1'b0; core_req = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (chip_select_n !== 1'b1 || core_stall !== 1'b1) begin
      err_cnt++; $display("FAIL rst_host_during: csn %b stall %b want 1 1", chip_select_n, core_stall);
    end
    tick();
    rst_n = 1'b1; host_req = 1'b0; core_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if ({chip_select_n, wr_en_n, output_en_n} !== 3'b111 || host_ack !== 1'b0 || core_valid !== 1'b0) begin
        err_cnt++; $display("FAIL rst_host_after: strobes %b ack %b valid %b want 111 0 0",
                            {chip_select_n, wr_en_n, output_en_n}, host_ack, core_valid);
      end
      tick();
    end
    // Reset during CORE: core_valid cleared.
    core_req = 1'b1;
    core_idle_stall("rst_core_idle");
    core_issue(9'h010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; core_req = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (core_valid !== 1'b0 || chip_select_n !== 1'b1) begin
      err_cnt++; $display("FAIL rst_core_after: valid %b csn %b want 0 1", core_valid, chip_select_n);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = pat(i);
      exp_mem[i] = pat(i);
    end
    ram_rdata = '0;
    last_rd = '0;
    test_reset();
    test_host_op(1'b1, 9'h005, {27'h5A5A5A5, 32'h01234567, 32'h89ABCDEF});
    test_host_op(1'b0, 9'h005, '0);
    test_host_op(1'b1, 9'h1FF, pat(77));
    test_host_op(1'b0, 9'h003, '0);
    test_host_op(1'b0, 9'h1FF, '0);
    test_core_stream();
    test_tie();
`ifdef RAM_ARB_STARVE_GUARD_EN
    test_starve();
`else
    test_strict_priority();
`endif
    test_reset_mid();
    vec_cnt++;
    if (core_q.size() != 0) begin
      err_cnt++; $display("FAIL core_reads_missing: %0d expected reads never returned", core_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
